ecc_scrub_ctrl: RTL and testbench

Background memory scrubber for the Hamming(7,4)-protected RAM. On command it walks addresses 0..DEPTH-1 over a shared memory port using a req/gnt handshake. It reads each 7-bit codeword and computes the syndrome. Any single-bit error is corrected and the fixed codeword is written back. It keeps error statistics and sits beside the host RAM port behind the existing port arbiter.

---
 rtl/ecc_scrub_ctrl_if.sv | 23 ++
 rtl/ecc_scrub_ctrl.sv | 141 ++++++++++++++
 tb/tb_ecc_scrub_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_scrub_ctrl_if.sv
// Shared memory port between the scrubber (master) and the port arbiter (slave).
// Codewords use bit indices 7:1 to match the Hamming(7,4) position numbering.
interface ecc_scrub_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              mem_req;
    logic              mem_gnt;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:1]        mem_wdata;
    logic [7:1]        mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_gnt, mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_gnt, mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber for Hamming(7,4) RAM: reads every word, corrects single-bit
// errors by writing back the fixed codeword, and keeps error statistics.
module ecc_scrub_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              parity_type,
    input  logic              clear_cnt,
    ecc_scrub_ctrl_if.master  mem,
    output logic              busy,
    output logic              done,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] last_err_addr
);
    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [7:1]        rd_word;
    logic [7:1]        fix_word;
    logic [2:0]        chk_pos;
    logic              abort_q;

    // pos = {s3,s2,s1}; parity_type folds odd parity into every check.
    function automatic logic [2:0] syndrome(input logic [7:1] c, input logic p);
        return {c[4] ^ c[5] ^ c[6] ^ c[7] ^ p,
                c[2] ^ c[3] ^ c[6] ^ c[7] ^ p,
                c[1] ^ c[3] ^ c[5] ^ c[7] ^ p};
    endfunction

    always_comb begin
        chk_pos  = syndrome(rd_word, parity_type);
        fix_word = rd_word;
        for (int i = 1; i <= 7; i++)
            if (chk_pos == 3'(i)) fix_word[i] = ~rd_word[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            rd_word       <= '0;
            abort_q       <= 1'b0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_pulse     <= 1'b0;
            err_count     <= '0;
            last_err_addr <= '0;
        end else begin
            done      <= 1'b0;
            err_pulse <= 1'b0;
            if (clear_cnt) err_count <= '0;
            if (state != IDLE && abort) abort_q <= 1'b1;

            case (state)
                IDLE: begin
                    abort_q <= 1'b0;
                    if (start) begin
                        addr         <= '0;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= '0;
                        busy         <= 1'b1;
                        state        <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Syndrome is evaluated on the incoming word so err_pulse lines up with CHECK.
                    if (mem.mem_rvalid) begin
                        rd_word   <= mem.mem_rdata;
                        err_pulse <= |syndrome(mem.mem_rdata, parity_type);
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (chk_pos != 3'd0) begin
                        if (!clear_cnt && err_count != '1) err_count <= err_count + 1'b1;
                        last_err_addr <= addr;
                        mem.mem_req   <= 1'b1;
                        mem.mem_we    <= 1'b1;
                        mem.mem_addr  <= addr;
                        mem.mem_wdata <= fix_word;
                        state         <= WR_REQ;
                    end else begin
                        state <= NEXT;
                    end
                end
                WR_REQ: begin
                    if (mem.mem_gnt) begin
                        mem.mem_req <= 1'b0;
                        mem.mem_we  <= 1'b0;
                        state       <= NEXT;
                    end
                end
                NEXT: begin
                    if (abort_q) begin
                        abort_q <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else if (addr == LAST_ADDR) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr         <= addr + 1'b1;
                        mem.mem_req  <= 1'b1;
                        mem.mem_we   <= 1'b0;
                        mem.mem_addr <= addr + 1'b1;
                        state        <= RD_REQ;
                    end
                end
                DONE: begin
                    // An abort seen here is dropped: the pass already completed.
                    abort_q <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: a transaction-timed model of the scrub walk plus a
// memory responder with random grant/rvalid latency, checked every cycle.
module tb_ecc_scrub_ctrl;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 2;
    localparam int BIG    = 32'h7fff_ffff;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              parity_type = 1'b0;
    logic              clear_cnt = 1'b0;
    logic              busy, done, err_pulse;
    logic [CNT_W-1:0]  err_count;
    logic [ADDR_W-1:0] last_err_addr;

    ecc_scrub_ctrl_if #(.ADDR_W(ADDR_W)) mif ();

    ecc_scrub_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .parity_type(parity_type), .clear_cnt(clear_cnt), .mem(mif.master),
        .busy(busy), .done(done), .err_pulse(err_pulse),
        .err_count(err_count), .last_err_addr(last_err_addr)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [7:1] mem [DEPTH];

    // model of expected behaviour, expressed as cycle numbers of upcoming events
    int b_from = 0, b_to = 0, rq_at = 0, rv_at = -1, next_at = -1;
    int done_at = -1, err_at = -1, inc_at = -1;
    bit rq_pend = 0, rq_we = 0, m_abort = 0;
    int rq_addr = 0, pass_addr = 0, pass_start = 0, m_cnt = 0, m_last = 0;
    logic [7:1] rq_wdata = '0, rv_data = '0;

    // stimulus knobs
    bit start_req = 0, rst_on_write = 0, clr_on_err = 0, clr_once = 0, rand_noise = 0;
    int gnt_pct = 100, rv_dmax = 1, clr_pct = 0, gnt_low_addr = -1, gnt_low_n = 0, abort_addr = -1;

    // observations of the DUT
    int obs_reads, obs_writes, dut_done_cyc, n_done, max_acc_addr, wr_addr_seen, req2_cyc;
    logic [7:1] wr_data_seen;
    bit prev_ep = 0;
    int cnt_seen[$];
    int exp5[4] = '{1, 2, 3, 3};

    function automatic logic [2:0] syn(input logic [7:1] c, input logic p);
        logic [2:0] s;
        s[0] = ^(c & 7'b1010101) ^ p;
        s[1] = ^(c & 7'b1100110) ^ p;
        s[2] = ^(c & 7'b1111000) ^ p;
        return s;
    endfunction

    function automatic logic [7:1] enc(input logic [3:0] d, input logic p);
        logic [7:1] c;
        c = '0;
        {c[7], c[6], c[5], c[3]} = d;
        c[1] = c[3] ^ c[5] ^ c[7] ^ p;
        c[2] = c[3] ^ c[6] ^ c[7] ^ p;
        c[4] = c[5] ^ c[6] ^ c[7] ^ p;
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        b_from = 0; b_to = 0; rq_pend = 0; rv_at = -1; next_at = -1;
        done_at = -1; err_at = -1; inc_at = -1; m_cnt = 0; m_last = 0; m_abort = 0;
    endtask

    task automatic step();
        bit exp_busy, exp_req, g;
        logic [2:0] pos;
        @(negedge clk);
        cyc++;
        exp_busy = (cyc >= b_from) && (cyc < b_to);
        exp_req  = rq_pend && (cyc >= rq_at);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("mem_req", 32'(mif.mem_req), 32'(exp_req));
        if (exp_req) begin
            chk("mem_we", 32'(mif.mem_we), 32'(rq_we));
            chk("mem_addr", 32'(mif.mem_addr), rq_addr);
            if (rq_we) chk("mem_wdata", 32'(mif.mem_wdata), 32'(rq_wdata));
        end
        chk("done", 32'(done), 32'(cyc == done_at));
        chk("err_pulse", 32'(err_pulse), 32'(cyc == err_at));
        chk("err_count", 32'(err_count), m_cnt);
        chk("last_err_addr", 32'(last_err_addr), m_last);
        if (done === 1'b1) begin dut_done_cyc = cyc; n_done++; end
        if (prev_ep) cnt_seen.push_back(int'(err_count));
        prev_ep = (err_pulse === 1'b1);
        if (mif.mem_req === 1'b1 && mif.mem_addr == 4'd2 && mif.mem_we === 1'b0) req2_cyc++;

        rst = 1'b0; start = 1'b0; abort = 1'b0; clear_cnt = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata  = 7'($urandom);
        g = ($urandom_range(99) < gnt_pct);
        if (exp_req && !rq_we && rq_addr == gnt_low_addr && gnt_low_n > 0) begin
            g = 1'b0;
            gnt_low_n--;
        end

        if (rst_on_write && exp_req && rq_we) begin
            rst = 1'b1;
            rst_on_write = 0;
            mif.mem_gnt = 1'b0;
            model_reset();
        end else begin
            mif.mem_gnt = g;
            if (mif.mem_req === 1'b1 && g) begin
                if (mif.mem_we === 1'b1) begin
                    obs_writes++;
                    wr_addr_seen = int'(mif.mem_addr);
                    wr_data_seen = mif.mem_wdata;
                end else obs_reads++;
                if (int'(mif.mem_addr) > max_acc_addr) max_acc_addr = int'(mif.mem_addr);
            end

            if (start_req && cyc >= b_to) begin
                start = 1'b1; start_req = 0;
                b_from = cyc + 1; b_to = BIG; m_abort = 0;
                pass_addr = 0; pass_start = cyc;
                rq_pend = 1; rq_at = cyc + 1; rq_we = 0; rq_addr = 0;
                obs_reads = 0; obs_writes = 0; dut_done_cyc = -1; n_done = 0;
                max_acc_addr = 0; wr_addr_seen = -1; wr_data_seen = '0; req2_cyc = 0;
            end else if (rand_noise && exp_busy && $urandom_range(7) == 0) begin
                start = 1'b1;
            end

            if (abort_addr >= 0 && rv_at >= 0 && pass_addr == abort_addr) begin
                abort = 1'b1;
                abort_addr = -1;
            end

            if (exp_req && g) begin
                rq_pend = 0;
                if (rq_we) begin
                    mem[rq_addr] = rq_wdata;
                    next_at = cyc + 1;
                end else begin
                    rv_at   = cyc + $urandom_range(rv_dmax, 1);
                    rv_data = mem[rq_addr];
                end
            end

            if (rv_at >= 0 && cyc == rv_at) begin
                mif.mem_rvalid = 1'b1;
                mif.mem_rdata  = rv_data;
                rv_at = -1;
                pos = syn(rv_data, parity_type);
                if (pos != 3'd0) begin
                    err_at = cyc + 1; inc_at = cyc + 1;
                    rq_pend = 1; rq_at = cyc + 2; rq_we = 1; rq_addr = pass_addr;
                    rq_wdata = rv_data ^ (7'd1 << (pos - 3'd1));
                end else begin
                    next_at = cyc + 2;
                end
            end else if (rand_noise && rv_at < 0 && $urandom_range(3) == 0) begin
                mif.mem_rvalid = 1'b1;
            end

            if (clr_once) begin clear_cnt = 1'b1; clr_once = 0; end
            else if (clr_on_err && cyc == inc_at) begin clear_cnt = 1'b1; clr_on_err = 0; end
            else if ($urandom_range(99) < clr_pct) clear_cnt = 1'b1;
            if (clear_cnt) m_cnt = 0;
            else if (cyc == inc_at && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (cyc == inc_at) m_last = pass_addr;

            if (cyc == next_at) begin
                if (m_abort) begin
                    b_to = cyc + 1; m_abort = 0;
                end else if (pass_addr == DEPTH - 1) begin
                    done_at = cyc + 1; b_to = cyc + 2;
                end else begin
                    pass_addr++;
                    rq_pend = 1; rq_at = cyc + 1; rq_we = 0; rq_addr = pass_addr;
                end
            end
            if (abort && exp_busy) m_abort = 1;
        end
    endtask

    task automatic run_pass(input int budget);
        int n;
        n = 0;
        start_req = 1;
        do begin step(); n++; end while ((start_req || cyc < b_to) && n < budget);
        if (start_req || cyc < b_to) begin
            n_chk++; n_fail++;
            $display("FAIL pass_timeout at cycle %0d: still running after %0d cycles, expected finished", cyc, budget);
            start_req = 0;
        end
    endtask

    task automatic fill_const(input logic [7:1] v);
        for (int i = 0; i < DEPTH; i++) mem[i] = v;
    endtask

    task automatic fill_rand(input logic p, input bit corrupt);
        logic [7:1] w;
        int r;
        for (int i = 0; i < DEPTH; i++) begin
            w = enc(4'($urandom), p);
            r = $urandom_range(99);
            if (corrupt && r < 25) w = w ^ 7'(1 << $urandom_range(6));
            else if (corrupt && r < 32) w = w ^ 7'(1 << $urandom_range(6)) ^ 7'(1 << $urandom_range(6));
            mem[i] = w;
        end
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
        repeat (2) @(posedge clk);
        idle_steps(2);

        // 1: clean pass, immediate grants
        fill_const(7'h55);
        run_pass(500);
        chk("t1_done_latency", dut_done_cyc - pass_start, 65);
        chk("t1_reads", obs_reads, 16);
        chk("t1_writes", obs_writes, 0);
        chk("t1_err_count", 32'(err_count), 0);

        // 2: single-bit error at addr 5
        mem[5] = 7'h51;
        run_pass(500);
        chk("t2_done_latency", dut_done_cyc - pass_start, 66);
        chk("t2_writes", obs_writes, 1);
        chk("t2_wr_addr", wr_addr_seen, 5);
        chk("t2_wr_data", 32'(wr_data_seen), 32'h55);
        chk("t2_err_count", 32'(err_count), 1);
        chk("t2_last_err_addr", 32'(last_err_addr), 5);

        // 3: grant withheld 3 cycles on the addr-2 read
        gnt_low_addr = 2; gnt_low_n = 3;
        run_pass(500);
        chk("t3_done_latency", dut_done_cyc - pass_start, 68);
        chk("t3_req2_cycles", req2_cyc, 4);
        gnt_low_addr = -1;

        // 4: abort during addr-7 read wait
        abort_addr = 7;
        run_pass(500);
        idle_steps(3);
        chk("t4_done_count", n_done, 0);
        chk("t4_max_addr", max_acc_addr, 7);
        chk("t4_reads", obs_reads, 8);
        chk("t4_busy", 32'(busy), 0);

        // 5: saturation with a 2-bit counter, then clear colliding with an increment
        clr_once = 1; idle_steps(2);
        fill_const(7'h55);
        mem[1] = 7'h54; mem[3] = 7'h57; mem[8] = 7'h45; mem[12] = 7'h15;
        cnt_seen.delete();
        run_pass(500);
        chk("t5_cnt_seq_len", cnt_seen.size(), 4);
        for (int i = 0; i < 4 && i < cnt_seen.size(); i++) chk("t5_cnt_seq", cnt_seen[i], exp5[i]);
        fill_const(7'h55);
        mem[4] = 7'h5d;
        clr_on_err = 1;
        run_pass(500);
        chk("t5_clear_wins", 32'(err_count), 0);
        chk("t5_last_err_addr", 32'(last_err_addr), 4);

        // 6: reset during write-back, then an odd-parity pass
        fill_const(7'h55);
        mem[3] = 7'h5d;
        rst_on_write = 1;
        run_pass(500);
        idle_steps(1);
        chk("t6_busy_after_rst", 32'(busy), 0);
        chk("t6_cnt_after_rst", 32'(err_count), 0);
        parity_type = 1'b1;
        fill_rand(1'b1, 0);
        run_pass(500);
        chk("t6_odd_writes", obs_writes, 0);
        chk("t6_odd_reads", obs_reads, 16);
        chk("t6_odd_latency", dut_done_cyc - pass_start, 65);
        chk("t6_odd_err_count", 32'(err_count), 0);

        // randomized passes
        gnt_pct = 55; rv_dmax = 3; clr_pct = 3; rand_noise = 1;
        for (int p = 0; p < 8; p++) begin
            parity_type = 1'($urandom);
            fill_rand(parity_type, 1);
            if (p % 3 == 2) abort_addr = $urandom_range(DEPTH - 1);
            run_pass(3000);
            abort_addr = -1;
            idle_steps($urandom_range(3, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
